exu_div_sched: RTL
==================

Name: exu_div_sched

Overview:
- Schedules the single shared iterative divider of the EXU between the two decode slots, I0 and I1.
- Arbitrates the requests and launches the divider with the captured operands.
- Resolves divide-by-zero and signed overflow locally, without using the divider.
- Returns the result with its destination tag, and cancels in-flight work on a lower flush.
- Drives the divide-stall/busy indication back to decode.

Parameters:
XLEN, 32, operand/result width
TAG_W, 5, destination register tag width
TIMEOUT, 40, divider watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i0_req  in  1  slot I0 divide request
i0_unsign  in  1  I0 unsigned op
i0_rem  in  1  I0 remainder select
i0_tag  in  TAG_W  I0 destination tag
i0_dividend  in  XLEN  I0 rs1
i0_divisor  in  XLEN  I0 rs2
i1_req, i1_unsign, i1_rem, i1_tag, i1_dividend, i1_divisor  in  same widths  slot I1 equivalents
i0_gnt  out  1  I0 request accepted this cycle
i1_gnt  out  1  I1 request accepted this cycle
flush  in  1  lower flush (dec_tlu_flush_lower_wb)
div_start  out  1  one-cycle launch pulse to divider
div_unsign  out  1  registered op attribute
div_rem  out  1  registered op attribute
div_dividend  out  XLEN  registered operand
div_divisor  out  XLEN  registered operand
div_cancel  out  1  one-cycle abort pulse to divider
div_done  in  1  divider result valid
div_result  in  XLEN  divider result
fin_valid  out  1  one-cycle result strobe
fin_tag  out  TAG_W  result tag
fin_result  out  XLEN  result data
busy  out  1  state != IDLE (divide stall)

Behaviour:
- Reset: state IDLE. All outputs 0. Internal operand/tag registers cleared.
- Reset mid-operation aborts immediately: no div_cancel, no fin_valid; the divider is reset by the same rst.
- States: IDLE, RUN, FIN.
- IDLE, arbitration:
  - Only when flush=0.
  - Fixed priority to I0 (older slot); I1 is granted only if i0_req=0.
  - At most one gnt per cycle. gnt is combinational from req, state and flush.
  - Granted request: latch unsign/rem/tag/operands.
- IDLE, special cases, resolved in the grant cycle, go to FIN without div_start:
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed (unsign=0) with dividend==0x8000_0000 and divisor==0xFFFF_FFFF: quotient = 0x8000_0000; remainder = 0.
- IDLE, normal case: next cycle div_start=1 for exactly one cycle, with registered operands stable from that cycle until leaving RUN; state RUN.
- RUN:
  - div_done=1: capture div_result → FIN.
  - div_done is ignored in IDLE and FIN.
- FIN: fin_valid=1 for one cycle with fin_tag/fin_result → IDLE. A new grant is possible the cycle after FIN.
- Flush:
  - In RUN: div_cancel=1 for one cycle; go IDLE. A div_done arriving in the same cycle is discarded.
  - In FIN: fin_valid suppressed; go IDLE.
  - In IDLE: no grant.
  - Flush wins over every other event.
- busy=1 in RUN and FIN; also 1 in the cycle after a grant.
- Latency:
  - Special case: gnt at N, fin_valid at N+1.
  - Normal case: gnt at N, div_start at N+1, fin_valid one cycle after div_done.
- Requests presented while busy are not granted; the requester holds them.

Optional Feature:
- Macro: EXU_DIV_SCHED_WATCHDOG_EN.
- Defined:
  - Adds a cycle counter, cleared on div_start and incremented in RUN.
  - Reaching TIMEOUT with no div_done: div_cancel pulse; fin_valid=1 with fin_result=0; go IDLE.
  - Adds output timeout_err (1 bit), set sticky until rst.
- Undefined: no counter, no timeout_err port; RUN waits indefinitely.

Test Plan:
- I0 signed 100/7, quotient; divider model done after 34 cycles → one div_start, fin_valid with fin_result=14 and I0 tag, busy low the cycle after FIN.
- i0_req and i1_req together (I0 rem 100%7, I1 tag 9) → i0_gnt only, fin_result=2. I1 held, granted in the first IDLE cycle after FIN, tag 9 returned.
- I1 unsigned 0x1234/0 quotient → no div_start, fin_valid at N+1 with 0xFFFF_FFFF. Same with rem → 0x1234.
- Signed 0x8000_0000 / 0xFFFF_FFFF: quotient → 0x8000_0000, remainder → 0, no div_start.
- Flush 5 cycles after div_start → div_cancel pulse, no fin_valid, IDLE. Flush coincident with div_done → result dropped.
- With EXU_DIV_SCHED_WATCHDOG_EN, TIMEOUT=40, divider never completes → div_cancel at cycle 40 after div_start, fin_result=0, timeout_err=1 until rst.

Source files
------------

// File: rtl/exu_div_sched.sv
// Shares one iterative divider between decode slots I0/I1, resolving divide-by-zero and signed overflow locally.
// Optional divider watchdog with sticky timeout_err: define EXU_DIV_SCHED_WATCHDOG_EN.
module exu_div_sched #(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 40
) (
`ifdef EXU_DIV_SCHED_WATCHDOG_EN
   output logic             timeout_err,
`endif
   input  logic             clk,
   input  logic             rst,
   input  logic             i0_req,
   input  logic             i0_unsign,
   input  logic             i0_rem,
   input  logic [TAG_W-1:0] i0_tag,
   input  logic [XLEN-1:0]  i0_dividend,
   input  logic [XLEN-1:0]  i0_divisor,
   input  logic             i1_req,
   input  logic             i1_unsign,
   input  logic             i1_rem,
   input  logic [TAG_W-1:0] i1_tag,
   input  logic [XLEN-1:0]  i1_dividend,
   input  logic [XLEN-1:0]  i1_divisor,
   output logic             i0_gnt,
   output logic             i1_gnt,
   input  logic             flush,
   output logic             div_start,
   output logic             div_unsign,
   output logic             div_rem,
   output logic [XLEN-1:0]  div_dividend,
   output logic [XLEN-1:0]  div_divisor,
   output logic             div_cancel,
   input  logic             div_done,
   input  logic [XLEN-1:0]  div_result,
   output logic             fin_valid,
   output logic [TAG_W-1:0] fin_tag,
   output logic [XLEN-1:0]  fin_result,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state, next_state;
   logic              grant, special, capture;
   logic              sel_unsign, sel_rem;
   logic [TAG_W-1:0]  sel_tag;
   logic [XLEN-1:0]   sel_dividend, sel_divisor, special_result;
   logic [TAG_W-1:0]  tag_q;
   logic [XLEN-1:0]   result_q;

`ifdef EXU_DIV_SCHED_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit;
`endif

   // I0 is the older slot, so it always wins when both request.
   assign i0_gnt = (state == IDLE) && !flush && i0_req;
   assign i1_gnt = (state == IDLE) && !flush && !i0_req && i1_req;
   assign grant  = i0_gnt || i1_gnt;

   assign sel_unsign   = i0_req ? i0_unsign   : i1_unsign;
   assign sel_rem      = i0_req ? i0_rem      : i1_rem;
   assign sel_tag      = i0_req ? i0_tag      : i1_tag;
   assign sel_dividend = i0_req ? i0_dividend : i1_dividend;
   assign sel_divisor  = i0_req ? i0_divisor  : i1_divisor;

   // Cases the divider would mishandle are answered directly in the grant cycle.
   always_comb begin
      special        = 1'b0;
      special_result = '0;
      if (sel_divisor == '0) begin
         special        = 1'b1;
         special_result = sel_rem ? sel_dividend : '1;
      end else if (!sel_unsign && (sel_dividend == MIN_NEG) && (sel_divisor == '1)) begin
         special        = 1'b1;
         special_result = sel_rem ? '0 : MIN_NEG;
      end
   end

   always_comb begin
      next_state = state;
      div_cancel = 1'b0;
      fin_valid  = 1'b0;
      capture    = 1'b0;
`ifdef EXU_DIV_SCHED_WATCHDOG_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: if (grant) next_state = special ? FIN : RUN;
         RUN: begin
            if (flush) begin
               div_cancel = 1'b1;
               next_state = IDLE;
            end else if (div_done) begin
               capture    = 1'b1;
               next_state = FIN;
`ifdef EXU_DIV_SCHED_WATCHDOG_EN
            end else if (cnt == TIMEOUT_CNT) begin
               div_cancel  = 1'b1;
               timeout_hit = 1'b1;
               next_state  = FIN;
`endif
            end
         end
         FIN: begin
            fin_valid  = !flush;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         div_start    <= 1'b0;
         div_unsign   <= 1'b0;
         div_rem      <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         tag_q        <= '0;
         result_q     <= '0;
      end else begin
         state     <= next_state;
         div_start <= grant && !special;
         if (grant) begin
            div_unsign   <= sel_unsign;
            div_rem      <= sel_rem;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            tag_q        <= sel_tag;
            result_q     <= special_result;
         end
         if (capture) result_q <= div_result;
`ifdef EXU_DIV_SCHED_WATCHDOG_EN
         if (timeout_hit) result_q <= '0;
`endif
      end
   end

`ifdef EXU_DIV_SCHED_WATCHDOG_EN
   // The launch cycle sees cnt==0, so the watchdog fires TIMEOUT cycles after div_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (grant) cnt <= '0;
         else if (state == RUN) cnt <= cnt + 1'b1;
         if (timeout_hit) timeout_err <= 1'b1;
      end
   end
`endif

   assign fin_tag    = tag_q;
   assign fin_result = result_q;
   assign busy       = (state != IDLE);

endmodule
